// File: rtl/csi2_pkt_stat.sv
// CSI2 packet statistics: error counters plus min/max lines-per-frame and pixels-per-line.
// Latency: every statistic output reflects its triggering strobe one clk_i edge later.
// Backpressure: none; decoder strobes are always accepted, and clear_stat_i drops coincident events.
module csi2_pkt_stat #(
    parameter int PX_PER_BEAT = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_stat_i,
    input  logic                 header_err_i,
    input  logic                 corr_header_err_i,
    input  logic                 crc_err_i,
    input  logic                 frame_start_i,
    input  logic                 frame_end_i,
    input  logic                 line_start_i,
    input  logic                 line_end_i,
    input  logic                 px_valid_i,
    output logic [CNT_WIDTH-1:0] header_err_cnt_o,
    output logic [CNT_WIDTH-1:0] corr_header_err_cnt_o,
    output logic [CNT_WIDTH-1:0] crc_err_cnt_o,
    output logic [CNT_WIDTH-1:0] max_ln_per_frame_o,
    output logic [CNT_WIDTH-1:0] min_ln_per_frame_o,
    output logic [CNT_WIDTH-1:0] max_px_per_ln_o,
    output logic [CNT_WIDTH-1:0] min_px_per_ln_o
);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam cnt_t PX_INC  = cnt_t'(PX_PER_BEAT);

    typedef struct packed {
        cnt_t hdr;
        cnt_t corr;
        cnt_t crc;
    } err_cnt_t;

    // Running extremes; lo starts at all-ones so the first sample always wins.
    typedef struct packed {
        cnt_t hi;
        cnt_t lo;
        logic vld;
    } range_t;

    localparam range_t RANGE_INIT = '{hi: '0, lo: CNT_MAX, vld: 1'b0};

    typedef enum logic { IDLE, IN_FRAME } frm_state_t;
    typedef enum logic { L_IDLE, IN_LINE } ln_state_t;

    function automatic cnt_t sat_add(input cnt_t a, input cnt_t b);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_WIDTH] ? CNT_MAX : sum[CNT_WIDTH-1:0];
    endfunction

    function automatic range_t range_upd(input range_t r, input cnt_t s);
        range_t n;
        n     = r;
        if (s > r.hi) n.hi = s;
        if (s < r.lo) n.lo = s;
        n.vld = 1'b1;
        return n;
    endfunction

    frm_state_t frm_q, frm_nxt;
    ln_state_t  lst_q, lst_nxt;
    cnt_t       ln_cnt_q, ln_cnt_nxt, ln_smp_dat;
    cnt_t       px_cnt_q, px_cnt_nxt, px_smp_dat;
    logic       ln_smp_vld, px_smp_vld;
    err_cnt_t   err_q;
    range_t     ln_rng_q, px_rng_q;

    // FSM state and running counters; clear leaves them untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frm_q    <= IDLE;
            lst_q    <= L_IDLE;
            ln_cnt_q <= '0;
            px_cnt_q <= '0;
        end else begin
            frm_q    <= frm_nxt;
            lst_q    <= lst_nxt;
            ln_cnt_q <= ln_cnt_nxt;
            px_cnt_q <= px_cnt_nxt;
        end
    end

    // Frame FSM: count lines inside a frame, emit a sample on frame end; restart discards.
    always_comb begin
        frm_nxt    = frm_q;
        ln_cnt_nxt = ln_cnt_q;
        ln_smp_vld = 1'b0;
        ln_smp_dat = ln_cnt_q;
        if (!clear_stat_i) begin
            if (frame_start_i) begin
                frm_nxt    = IN_FRAME;
                ln_cnt_nxt = '0;
            end else if (frm_q == IN_FRAME) begin
                if (line_start_i) ln_cnt_nxt = sat_add(ln_cnt_q, CNT_ONE);
                if (frame_end_i) begin
                    frm_nxt    = IDLE;
                    ln_smp_vld = 1'b1;
                    ln_smp_dat = ln_cnt_nxt;
                end
            end
        end
    end

    // Line FSM: accumulate pixels, sample on line end including a same-cycle beat.
    always_comb begin
        lst_nxt    = lst_q;
        px_cnt_nxt = px_cnt_q;
        px_smp_vld = 1'b0;
        px_smp_dat = px_cnt_q;
        if (!clear_stat_i) begin
            if (line_start_i) begin
                lst_nxt    = IN_LINE;
                px_cnt_nxt = px_valid_i ? PX_INC : '0;
            end else if (lst_q == IN_LINE && px_valid_i) begin
                px_cnt_nxt = sat_add(px_cnt_q, PX_INC);
            end
            if (line_end_i && (line_start_i || lst_q == IN_LINE)) begin
                lst_nxt    = L_IDLE;
                px_smp_vld = 1'b1;
                px_smp_dat = px_cnt_nxt;
            end
        end
    end

    // Statistics registers; clear wins over every event in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q    <= '0;
            ln_rng_q <= RANGE_INIT;
            px_rng_q <= RANGE_INIT;
        end else if (clear_stat_i) begin
            err_q    <= '0;
            ln_rng_q <= RANGE_INIT;
            px_rng_q <= RANGE_INIT;
        end else begin
            if (header_err_i)      err_q.hdr  <= sat_add(err_q.hdr, CNT_ONE);
            if (corr_header_err_i) err_q.corr <= sat_add(err_q.corr, CNT_ONE);
            if (crc_err_i)         err_q.crc  <= sat_add(err_q.crc, CNT_ONE);
            if (ln_smp_vld)        ln_rng_q   <= range_upd(ln_rng_q, ln_smp_dat);
            if (px_smp_vld)        px_rng_q   <= range_upd(px_rng_q, px_smp_dat);
        end
    end

    assign header_err_cnt_o      = err_q.hdr;
    assign corr_header_err_cnt_o = err_q.corr;
    assign crc_err_cnt_o         = err_q.crc;
    assign max_ln_per_frame_o    = ln_rng_q.hi;
    assign min_ln_per_frame_o    = ln_rng_q.vld ? ln_rng_q.lo : '0;
    assign max_px_per_ln_o       = px_rng_q.hi;
    assign min_px_per_ln_o       = px_rng_q.vld ? px_rng_q.lo : '0;

endmodule

// File: tb/tb_csi2_pkt_stat.sv
// Bench for csi2_pkt_stat: vector table through a scoreboard queue, plus reset and saturation sequences.
// Latency: expectations are compared #1 after the edge that follows the driven inputs.
// Backpressure: none; the DUT accepts a strobe every cycle.
module tb_csi2_pkt_stat;

    typedef logic [31:0] w_t;

    typedef struct packed {
        w_t hdr;
        w_t corr;
        w_t crc;
        w_t xl;
        w_t nl;
        w_t xp;
        w_t np;
    } exp_t;

    typedef struct {
        logic [8:0] in;
        exp_t       e;
    } vec_t;

    localparam logic [8:0] NONE = 9'h000;
    localparam logic [8:0] CLR  = 9'h100;
    localparam logic [8:0] HDR  = 9'h080;
    localparam logic [8:0] CORR = 9'h040;
    localparam logic [8:0] CRC  = 9'h020;
    localparam logic [8:0] FS   = 9'h010;
    localparam logic [8:0] FE   = 9'h008;
    localparam logic [8:0] LS   = 9'h004;
    localparam logic [8:0] LE   = 9'h002;
    localparam logic [8:0] PV   = 9'h001;

    logic clk = 1'b0;
    logic rst;
    logic clr, hdr, corr, crc, fs, fe, ls, le, pv;
    w_t   hdr_cnt, corr_cnt, crc_cnt, max_ln, min_ln, max_px, min_px;

    logic       zero = 1'b0;
    logic       s_hdr;
    logic [3:0] s_hdr_cnt, s_corr_cnt, s_crc_cnt, s_max_ln, s_min_ln, s_max_px, s_min_px;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    csi2_pkt_stat #(.PX_PER_BEAT(2), .CNT_WIDTH(32)) u_dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .clear_stat_i          (clr),
        .header_err_i          (hdr),
        .corr_header_err_i     (corr),
        .crc_err_i             (crc),
        .frame_start_i         (fs),
        .frame_end_i           (fe),
        .line_start_i          (ls),
        .line_end_i            (le),
        .px_valid_i            (pv),
        .header_err_cnt_o      (hdr_cnt),
        .corr_header_err_cnt_o (corr_cnt),
        .crc_err_cnt_o         (crc_cnt),
        .max_ln_per_frame_o    (max_ln),
        .min_ln_per_frame_o    (min_ln),
        .max_px_per_ln_o       (max_px),
        .min_px_per_ln_o       (min_px)
    );

    // Narrow instance so counter saturation is reachable in a few cycles.
    csi2_pkt_stat #(.PX_PER_BEAT(1), .CNT_WIDTH(4)) u_sat (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .clear_stat_i          (zero),
        .header_err_i          (s_hdr),
        .corr_header_err_i     (zero),
        .crc_err_i             (zero),
        .frame_start_i         (zero),
        .frame_end_i           (zero),
        .line_start_i          (zero),
        .line_end_i            (zero),
        .px_valid_i            (zero),
        .header_err_cnt_o      (s_hdr_cnt),
        .corr_header_err_cnt_o (s_corr_cnt),
        .crc_err_cnt_o         (s_crc_cnt),
        .max_ln_per_frame_o    (s_max_ln),
        .min_ln_per_frame_o    (s_min_ln),
        .max_px_per_ln_o       (s_max_px),
        .min_px_per_ln_o       (s_min_px)
    );

    function automatic exp_t E(input w_t h, input w_t c, input w_t r, input w_t xl,
                               input w_t nl, input w_t xp, input w_t np);
        exp_t e;
        e = '{hdr: h, corr: c, crc: r, xl: xl, nl: nl, xp: xp, np: np};
        return e;
    endfunction

    function automatic vec_t V(input logic [8:0] i, input exp_t e);
        vec_t v;
        v.in = i;
        v.e  = e;
        return v;
    endfunction

    task automatic chk(input string name, input w_t act, input w_t req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic drive(input logic [8:0] i);
        {clr, hdr, corr, crc, fs, fe, ls, le, pv} = i;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL %s.queue: got empty scoreboard, expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".hdr_err"},  hdr_cnt,  e.hdr);
            chk({tag, ".corr_err"}, corr_cnt, e.corr);
            chk({tag, ".crc_err"},  crc_cnt,  e.crc);
            chk({tag, ".max_ln"},   max_ln,   e.xl);
            chk({tag, ".min_ln"},   min_ln,   e.nl);
            chk({tag, ".max_px"},   max_px,   e.xp);
            chk({tag, ".min_px"},   min_px,   e.np);
        end
    endtask

    task automatic step(input string tag, input logic [8:0] i, input exp_t e);
        @(negedge clk);
        drive(i);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, then error counters.
        tbl.push_back(V(NONE,            E(0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(V(HDR | CORR | CRC, E(1, 1, 1, 0, 0, 0, 0)));
        tbl.push_back(V(HDR | CORR,      E(2, 2, 1, 0, 0, 0, 0)));
        tbl.push_back(V(HDR,             E(3, 2, 1, 0, 0, 0, 0)));
        // Frame of 4 lines; min_ln reads 0 until the frame ends.
        tbl.push_back(V(FS,              E(3, 2, 1, 0, 0, 0, 0)));
        for (int i = 0; i < 4; i++)
            tbl.push_back(V(LS,          E(3, 2, 1, 0, 0, 0, 0)));
        tbl.push_back(V(FE,              E(3, 2, 1, 4, 4, 0, 0)));
        // Frame of 2 lines.
        tbl.push_back(V(FS,              E(3, 2, 1, 4, 4, 0, 0)));
        tbl.push_back(V(LS,              E(3, 2, 1, 4, 4, 0, 0)));
        tbl.push_back(V(LS,              E(3, 2, 1, 4, 4, 0, 0)));
        tbl.push_back(V(FE,              E(3, 2, 1, 4, 2, 0, 0)));
        // 5-beat line at 2 px/beat, line_end on the 5th beat.
        tbl.push_back(V(LS | PV,         E(3, 2, 1, 4, 2, 0, 0)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(V(PV,          E(3, 2, 1, 4, 2, 0, 0)));
        tbl.push_back(V(LE | PV,         E(3, 2, 1, 4, 2, 10, 10)));
        // 3-beat line, then a single-beat line.
        tbl.push_back(V(LS | PV,         E(3, 2, 1, 4, 2, 10, 10)));
        tbl.push_back(V(PV,              E(3, 2, 1, 4, 2, 10, 10)));
        tbl.push_back(V(LE | PV,         E(3, 2, 1, 4, 2, 10, 6)));
        tbl.push_back(V(LS | LE | PV,    E(3, 2, 1, 4, 2, 10, 2)));
        // Clear coincident with crc and frame_end: all dropped; open frame completes later.
        tbl.push_back(V(FS,              E(3, 2, 1, 4, 2, 10, 2)));
        tbl.push_back(V(LS,              E(3, 2, 1, 4, 2, 10, 2)));
        tbl.push_back(V(CLR | CRC | FE,  E(0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(V(NONE,            E(0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(V(FE,              E(0, 0, 0, 1, 1, 0, 0)));
        // Restarted frame discards its 3 partial lines.
        tbl.push_back(V(CLR,             E(0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(V(FS,              E(0, 0, 0, 0, 0, 0, 0)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(V(LS,          E(0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(V(FS,              E(0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(V(LS,              E(0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(V(FE,              E(0, 0, 0, 1, 1, 0, 0)));

        rst   = 1'b1;
        s_hdr = 1'b0;
        drive(NONE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i])
            step($sformatf("v%0d", i), tbl[i].in, tbl[i].e);

        // Reset inside an open frame: a lone frame_end must produce no sample.
        step("rf_fs", FS, E(0, 0, 0, 1, 1, 0, 0));
        step("rf_ls", LS, E(0, 0, 0, 1, 1, 0, 0));
        @(negedge clk);
        drive(NONE);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step("rf_fe", FE, E(0, 0, 0, 0, 0, 0, 0));
        step("stray_le", LE, E(0, 0, 0, 0, 0, 0, 0));
        step("stray_pv", PV, E(0, 0, 0, 0, 0, 0, 0));
        step("stray_lepv", LE | PV, E(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(NONE);

        // Saturation on the 4-bit instance: 18 strobes, count stops at 15.
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            s_hdr = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d", i), {28'd0, s_hdr_cnt}, (i > 15) ? w_t'(15) : w_t'(i));
        end
        @(negedge clk);
        s_hdr = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_hold", {28'd0, s_hdr_cnt}, w_t'(15));
        chk("sat_crc_idle", {28'd0, s_crc_cnt}, w_t'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
